// File: rtl/abacus_pkg.sv
// Shared types and constants for the cache fill latency tracker.
package abacus_pkg;

  localparam int unsigned DEFAULT_COUNTER_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fill_latency_tracker_if.sv
// Control, fill-activity and statistics bundle between the core/profiler and the tracker.
interface fill_latency_tracker_if #(
  parameter int unsigned COUNTER_WIDTH = abacus_pkg::DEFAULT_COUNTER_WIDTH
) ();

  logic                     enable;
  logic                     clear;
  logic                     icache_line_fill_in_progress;
  logic                     dcache_line_fill_in_progress;
  logic [COUNTER_WIDTH-1:0] icache_fill_count;
  logic [COUNTER_WIDTH-1:0] dcache_fill_count;
  logic [COUNTER_WIDTH-1:0] icache_fill_cycles;
  logic [COUNTER_WIDTH-1:0] dcache_fill_cycles;
  logic [COUNTER_WIDTH-1:0] icache_fill_max;
  logic [COUNTER_WIDTH-1:0] dcache_fill_max;
  logic                     busy;

  modport master (
    output enable, clear, icache_line_fill_in_progress, dcache_line_fill_in_progress,
    input  icache_fill_count, dcache_fill_count, icache_fill_cycles, dcache_fill_cycles,
    input  icache_fill_max, dcache_fill_max, busy
  );

  modport slave (
    input  enable, clear, icache_line_fill_in_progress, dcache_line_fill_in_progress,
    output icache_fill_count, dcache_fill_count, icache_fill_cycles, dcache_fill_cycles,
    output icache_fill_max, dcache_fill_max, busy
  );

endinterface

// File: rtl/fill_latency_channel.sv
// One cache channel: counts fills, accumulates fill cycles, optionally tracks the longest fill.
// Longest-fill tracking is built only when ABACUS_FILL_MAX_TRACK_EN is defined.
module fill_latency_channel
  import abacus_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     in_progress,
  output logic [COUNTER_WIDTH-1:0] fill_count,
  output logic [COUNTER_WIDTH-1:0] fill_cycles,
  output logic [COUNTER_WIDTH-1:0] fill_max,
  output logic                     filling
);

  fill_state_t              state;
  fill_state_t              next_state;
  logic                     prev;
  logic                     started;
  logic [COUNTER_WIDTH-1:0] count_nx;
  logic [COUNTER_WIDTH-1:0] cycles_nx;
`ifdef ABACUS_FILL_MAX_TRACK_EN
  logic [COUNTER_WIDTH-1:0] cur_len;
  logic [COUNTER_WIDTH-1:0] len_nx;
  logic [COUNTER_WIDTH-1:0] max_nx;
`endif

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + COUNTER_WIDTH'(1);
  endfunction

  // started gates the first clock after reset so a fill already in flight falls into DRAIN
  always_comb begin
    next_state = state;
    count_nx   = fill_count;
    cycles_nx  = fill_cycles;
`ifdef ABACUS_FILL_MAX_TRACK_EN
    len_nx     = cur_len;
    max_nx     = fill_max;
`endif
    if (clear) begin
      next_state = in_progress ? DRAIN : IDLE;
      count_nx   = '0;
      cycles_nx  = '0;
`ifdef ABACUS_FILL_MAX_TRACK_EN
      len_nx     = '0;
      max_nx     = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!started) begin
            if (in_progress) next_state = DRAIN;
          end else if (enable && in_progress && !prev) begin
            next_state = FILL;
            count_nx   = sat_inc(fill_count);
            cycles_nx  = sat_inc(fill_cycles);
`ifdef ABACUS_FILL_MAX_TRACK_EN
            len_nx     = COUNTER_WIDTH'(1);
`endif
          end
        end
        FILL: begin
          if (in_progress) begin
            cycles_nx = sat_inc(fill_cycles);
`ifdef ABACUS_FILL_MAX_TRACK_EN
            len_nx    = sat_inc(cur_len);
`endif
          end else begin
            next_state = IDLE;
`ifdef ABACUS_FILL_MAX_TRACK_EN
            max_nx     = (cur_len > fill_max) ? cur_len : fill_max;
`endif
          end
        end
        DRAIN: begin
          if (!in_progress) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prev        <= 1'b0;
      started     <= 1'b0;
      fill_count  <= '0;
      fill_cycles <= '0;
      filling     <= 1'b0;
`ifdef ABACUS_FILL_MAX_TRACK_EN
      cur_len     <= '0;
      fill_max    <= '0;
`endif
    end else begin
      state       <= next_state;
      prev        <= in_progress;
      started     <= 1'b1;
      fill_count  <= count_nx;
      fill_cycles <= cycles_nx;
      filling     <= (next_state == FILL);
`ifdef ABACUS_FILL_MAX_TRACK_EN
      cur_len     <= len_nx;
      fill_max    <= max_nx;
`endif
    end
  end

`ifndef ABACUS_FILL_MAX_TRACK_EN
  assign fill_max = '0;
`endif

endmodule

// File: rtl/fill_latency_tracker.sv
// Instruction- and data-cache fill latency statistics; two independent channels plus a busy flag.
// Longest-fill tracking is enabled by ABACUS_FILL_MAX_TRACK_EN.
module fill_latency_tracker
  import abacus_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  fill_latency_tracker_if.slave bus
);

  logic i_filling;
  logic d_filling;

  fill_latency_channel #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .enable      (bus.enable),
    .clear       (bus.clear),
    .in_progress (bus.icache_line_fill_in_progress),
    .fill_count  (bus.icache_fill_count),
    .fill_cycles (bus.icache_fill_cycles),
    .fill_max    (bus.icache_fill_max),
    .filling     (i_filling)
  );

  fill_latency_channel #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_dcache (
    .clk         (clk),
    .rst         (rst),
    .enable      (bus.enable),
    .clear       (bus.clear),
    .in_progress (bus.dcache_line_fill_in_progress),
    .fill_count  (bus.dcache_fill_count),
    .fill_cycles (bus.dcache_fill_cycles),
    .fill_max    (bus.dcache_fill_max),
    .filling     (d_filling)
  );

  // both flags are flops, so busy tracks the FILL states with no extra delay
  assign bus.busy = i_filling | d_filling;

endmodule
